// File: rtl/kgp_pkg.sv
// Shared RISC-KGP definitions: default memory geometry, the read-return
// owner encoding, and a small saturating-counter helper.
package kgp_pkg;

  localparam int unsigned KGP_ADDR_W = 10;
  localparam int unsigned KGP_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } rd_owner_e;

  // Increment a 4-bit counter, holding at the supplied ceiling.
  function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic [3:0] ceil);
    logic [3:0] res;
    if (cnt < ceil) begin
      res = cnt + 4'd1;
    end else begin
      res = ceil;
    end
    return res;
  endfunction

endpackage

// File: rtl/kgp_mem_arbiter.sv
// Shares one synchronous-read BRAM port between instruction fetch and the
// load/store unit: data wins by default, fetch is forced through after a bounded wait.
module kgp_mem_arbiter
  import kgp_pkg::*;
#(
  parameter int unsigned ADDR_W       = KGP_ADDR_W,
  parameter int unsigned DATA_W       = KGP_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_r;
  logic [3:0]        starve_cnt_nxt_s;
  rd_owner_e         rd_owner_r;
  rd_owner_e         rd_owner_nxt_s;
  logic              if_gnt_s;
  logic              dm_gnt_s;
  logic [ADDR_W-1:0] last_addr_r;
  logic [DATA_W-1:0] last_wdata_r;

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    if_gnt_s = 1'b0;
    dm_gnt_s = 1'b0;
    if (!reset) begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end else if (if_req && dm_req) begin
      if (starve_cnt_r == LIMIT) begin
        if_gnt_s = 1'b1;
      end else begin
        dm_gnt_s = 1'b1;
      end
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else if (dm_req) begin
      dm_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end
  end

  // Starvation counter and read-return owner next state.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    rd_owner_nxt_s   = OWN_NONE;
    if (if_gnt_s || !if_req) begin
      starve_cnt_nxt_s = 4'd0;
    end else begin
      starve_cnt_nxt_s = sat_inc4(starve_cnt_r, LIMIT);
    end
    if (if_gnt_s) begin
      rd_owner_nxt_s = OWN_IF;
    end else if (dm_gnt_s && !dm_we) begin
      rd_owner_nxt_s = OWN_DM;
    end else begin
      rd_owner_nxt_s = OWN_NONE;
    end
  end

  // Arbitration state; a reset mid-read drops the pending return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 4'd0;
      rd_owner_r   <= OWN_NONE;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      rd_owner_r   <= rd_owner_nxt_s;
    end
  end

  // Memory port mux; address and write data hold when idle.
  always_comb begin
    mem_en    = if_gnt_s | dm_gnt_s;
    mem_we    = dm_gnt_s & dm_we;
    mem_addr  = last_addr_r;
    mem_wdata = last_wdata_r;
    if (if_gnt_s) begin
      mem_addr  = if_addr;
      mem_wdata = last_wdata_r;
    end else if (dm_gnt_s) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else begin
      mem_addr  = last_addr_r;
      mem_wdata = last_wdata_r;
    end
  end

  // Remember the last driven address/data so idle cycles do not toggle the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_r  <= '0;
      last_wdata_r <= '0;
    end else begin
      last_addr_r  <= mem_addr;
      last_wdata_r <= mem_wdata;
    end
  end

  // Requester handshakes and read-data steering.
  always_comb begin
    if_gnt   = if_gnt_s;
    dm_gnt   = dm_gnt_s;
    if_stall = reset & if_req & ~if_gnt_s;
    dm_stall = reset & dm_req & ~dm_gnt_s;
    if_valid = 1'b0;
    dm_valid = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    case (rd_owner_r)
      OWN_IF: begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      OWN_DM: begin
        dm_valid = 1'b1;
        dm_rdata = mem_rdata;
      end
      default: begin
        if_valid = 1'b0;
        dm_valid = 1'b0;
      end
    endcase
  end

endmodule
